// File: rtl/pwm_pkg.sv
// Definitions shared by the PWM generator, note sequencer and capture blocks.
package pwm_pkg;

  localparam int PWM_TOP_WIDTH = 8;
  localparam int PERIOD_MAX    = 2 ** PWM_TOP_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module bit_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between successive rising edges
// and reports them as top (period-1) and compare (high clocks).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int TOP_WIDTH   = PWM_TOP_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pwm,
  output logic [TOP_WIDTH-1:0] o_top,
  output logic [TOP_WIDTH:0]   o_compare,
  output logic                 o_valid,
  output logic                 o_timeout,
  output logic                 o_level
);

  localparam int            CW      = TOP_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_SAT = (CNT_ONE << TOP_WIDTH) + CNT_ONE;

  logic                 w_s;
  logic                 w_rise;
  logic [CW-1:0]        w_period_next;
  logic [CW-1:0]        w_high_next;
  logic                 r_prev;
  state_t               r_state;
  logic [CW-1:0]        r_cnt_period;
  logic [CW-1:0]        r_cnt_high;
  logic [TOP_WIDTH-1:0] r_top;
  logic [CW-1:0]        r_compare;
  logic                 r_valid;
  logic                 r_timeout;
  logic                 r_level;

  // Reset high so a pin already high at reset release is not a rising edge.
  bit_synchronizer #(
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(1'b1)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_pwm),
    .o_q  (w_s)
  );

  assign w_rise        = w_s & ~r_prev;
  assign w_period_next = (r_cnt_period == CNT_SAT) ? CNT_SAT : r_cnt_period + CNT_ONE;
  assign w_high_next   = (w_s && (r_cnt_high != CNT_SAT)) ? r_cnt_high + CNT_ONE : r_cnt_high;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev       <= 1'b1;
      r_state      <= ST_IDLE;
      r_cnt_period <= '0;
      r_cnt_high   <= '0;
      r_top        <= '0;
      r_compare    <= '0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_level      <= 1'b0;
    end else begin
      r_prev    <= w_s;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;

      if (w_rise) begin
        r_cnt_period <= CNT_ONE;
        r_cnt_high   <= CNT_ONE;
      end else begin
        r_cnt_period <= w_period_next;
        r_cnt_high   <= w_high_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // A rise reloads the counters, so it always wins over overflow.
          if (w_rise) begin
            r_top     <= TOP_WIDTH'(r_cnt_period - CNT_ONE);
            r_compare <= r_cnt_high;
            r_valid   <= 1'b1;
          end else if (w_period_next == CNT_SAT) begin
            r_timeout <= 1'b1;
            r_level   <= w_s;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_top     = r_top;
  assign o_compare = r_compare;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;
  assign o_level   = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a second instance for synchronizer latency.
module tb_pwm_capture;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm = 1'b1;
  logic [TW-1:0] o_top;
  logic [TW:0]   o_compare;
  logic          o_valid;
  logic          o_timeout;
  logic          o_level;
  logic [TW-1:0] o3_top;
  logic [TW:0]   o3_compare;
  logic          o3_valid;
  logic          o3_timeout;
  logic          o3_level;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_valid3 = 0;
  int n_to = 0;
  int n_both = 0;
  int last_top = 0;
  int last_cmp = 0;
  int last_level = 0;
  int last_gap = 0;
  int valid_cyc = 0;
  int to_cyc = 0;
  int lat2 = -1;
  int lat3 = -1;

  pwm_capture #(.TOP_WIDTH(TW), .SYNC_STAGES(2)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pwm    (pwm),
    .o_top    (o_top),
    .o_compare(o_compare),
    .o_valid  (o_valid),
    .o_timeout(o_timeout),
    .o_level  (o_level)
  );

  pwm_capture #(.TOP_WIDTH(TW), .SYNC_STAGES(3)) dut3 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pwm    (pwm),
    .o_top    (o3_top),
    .o_compare(o3_compare),
    .o_valid  (o3_valid),
    .o_timeout(o3_timeout),
    .o_level  (o3_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive the pin for one clock, then record any strobes seen after the edge.
  task automatic step(input logic pin);
    pwm = pin;
    @(posedge clk);
    #1;
    cyc++;
    if (o_valid && o_timeout) n_both++;
    if (o_valid) begin
      n_valid++;
      last_gap  = cyc - valid_cyc;
      valid_cyc = cyc;
      last_top  = int'(o_top);
      last_cmp  = int'(o_compare);
    end
    if (o_timeout) begin
      n_to++;
      to_cyc     = cyc;
      last_level = int'(o_level);
    end
    if (o3_valid) n_valid3++;
  endtask

  task automatic hold(input logic pin, input int n);
    repeat (n) step(pin);
  endtask

  task automatic periods(input int top, input int cmp, input int n);
    repeat (n) begin
      hold(1'b1, cmp);
      hold(1'b0, top + 1 - cmp);
    end
  endtask

  task automatic clear_stats();
    n_valid  = 0;
    n_valid3 = 0;
    n_to     = 0;
  endtask

  initial begin
    rst = 1'b1;
    hold(1'b1, 4);
    check("rst_top", 32'(o_top), 0);
    check("rst_compare", 32'(o_compare), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    check("rst_level", 32'(o_level), 0);
    clear_stats();

    // Pin high across reset release: first rise only arms the measurement.
    rst = 1'b0;
    hold(1'b1, 4);
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 5);
    check("rel_no_early_valid", n_valid, 0);
    check("rel_no_timeout", n_to, 0);
    hold(1'b1, 8);
    check("rel_valid_count", n_valid, 1);
    check("rel_top", last_top, 9);
    check("rel_compare", last_cmp, 5);

    // Minimum period: 1 high, 1 low.
    clear_stats();
    repeat (12) begin
      hold(1'b0, 1);
      hold(1'b1, 1);
    end
    check("min_valid_count", n_valid, 11);
    check("min_top", last_top, 1);
    check("min_compare", last_cmp, 1);
    check("min_gap", last_gap, 2);
    hold(1'b0, 4);

    // Loopback-style stream, top=99 compare=25.
    clear_stats();
    periods(99, 25, 5);
    check("loop_valid_count", n_valid, 5);
    check("loop_top", last_top, 99);
    check("loop_compare", last_cmp, 25);
    check("loop_gap", last_gap, 100);
    check("loop_no_timeout", n_to, 0);
    check("loop_valid_count_s3", n_valid3, 5);

    // Maximum period, top=255 compare=128.
    clear_stats();
    periods(255, 128, 3);
    check("max_valid_count", n_valid, 3);
    check("max_top", last_top, 255);
    check("max_compare", last_cmp, 128);
    check("max_gap", last_gap, 256);
    check("max_no_timeout", n_to, 0);

    // Period 257 overflows: timeout 256 clocks after the preceding strobe.
    clear_stats();
    hold(1'b1, 1);
    hold(1'b0, 256);
    hold(1'b1, 2);
    check("ovf_valid_count", n_valid, 1);
    check("ovf_prev_top", last_top, 255);
    check("ovf_timeout_count", n_to, 1);
    check("ovf_level", last_level, 0);
    check("ovf_timeout_delay", to_cyc - valid_cyc, 256);

    // Constant high (100% duty) after the rise.
    clear_stats();
    hold(1'b1, 300);
    check("high_timeout_count", n_to, 1);
    check("high_level", last_level, 1);
    check("high_no_valid", n_valid, 0);

    // Recovery from IDLE, top=9 compare=4.
    clear_stats();
    hold(1'b0, 6);
    hold(1'b1, 4);
    hold(1'b0, 6);
    check("rec_first_rise_silent", n_valid, 0);
    hold(1'b1, 4);
    hold(1'b0, 6);
    check("rec_valid_count", n_valid, 1);
    check("rec_top", last_top, 9);
    check("rec_compare", last_cmp, 4);
    check("rec_level_held", 32'(o_level), 1);
    check("rec_no_timeout", n_to, 0);

    // Reset in the middle of a high phase.
    hold(1'b1, 2);
    rst = 1'b1;
    step(1'b1);
    check("mid_rst_top", 32'(o_top), 0);
    check("mid_rst_compare", 32'(o_compare), 0);
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_timeout", 32'(o_timeout), 0);
    check("mid_rst_level", 32'(o_level), 0);
    rst = 1'b0;
    clear_stats();
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 4);
    hold(1'b0, 6);
    check("mid_rst_no_valid", n_valid, 0);
    hold(1'b1, 4);
    hold(1'b0, 6);
    check("mid_rst_valid_count", n_valid, 1);
    check("mid_rst_top_after", last_top, 9);
    check("mid_rst_cmp_after", last_cmp, 4);

    // Latency: clock edges from first sampling of the rise to o_valid.
    hold(1'b0, 10);
    for (int j = 0; j < 8; j++) begin
      step(1'b1);
      if (o_valid && lat2 < 0) lat2 = j + 1;
      if (o3_valid && lat3 < 0) lat3 = j + 1;
    end
    check("latency_sync2", lat2, 3);
    check("latency_sync3", lat3, 4);
    check("valid_timeout_exclusive", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM receiver/demodulator, the receive end of the pwm output stream. It samples an external PWM pin and measures the period and high time of each cycle, rising edge to rising edge. It reports them in the same top/compare encoding the pwm block consumes: period = top+1 clocks, high = compare clocks. It is used for loopback self-test of the pwm path and for capturing external PWM sources on a PMOD pin.

Parameters:
TOP_WIDTH, 8, width of o_top; o_compare is TOP_WIDTH+1 bits; max measurable period 2^TOP_WIDTH clocks
SYNC_STAGES, 2, input synchronizer depth (>=2)

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, synchronous, active-high
i_pwm  input  1  asynchronous PWM input pin
o_top  output  TOP_WIDTH  measured period minus 1
o_compare  output  TOP_WIDTH+1  measured high time in clocks
o_valid  output  1  one-cycle strobe: o_top/o_compare updated this cycle
o_timeout  output  1  one-cycle strobe: no rising edge within 2^TOP_WIDTH clocks
o_level  output  1  synchronized pin level, registered when o_timeout fires

Behaviour:
- One clock; reset is synchronous and active-high on i_clk/i_rst.
- Synchronizer: SYNC_STAGES flops plus one previous-value flop. All of these reset to 1, so a pin that is high at reset release is not seen as a rising edge.
- Edge detect: rise = s & ~prev, where s is the last synchronizer stage.
- Counters: cnt_period and cnt_high, each TOP_WIDTH+1 bits.
  - On rise: both load 1.
  - Otherwise: cnt_period increments every cycle; cnt_high increments only while s=1.
  - Both saturate at 2^TOP_WIDTH+1.
- FSM, 2 states:
  - IDLE (reset state): wait for rise. On rise, load counters and go to MEASURE. No output strobe.
  - MEASURE, on rise: register o_top=cnt_period-1 and o_compare=cnt_high, pulse o_valid for 1 cycle, reload counters, stay in MEASURE.
  - MEASURE, when cnt_period reaches 2^TOP_WIDTH+1 with no rise: pulse o_timeout, register o_level=s, go to IDLE. o_top/o_compare are unchanged.
  - MEASURE, rise and overflow in the same cycle: impossible, because rise reloads the counters. Rise takes priority.
- Latency: pin edge sampled at clock edge k → o_valid high in the cycle following edge k+SYNC_STAGES.
- Measured ranges: period 2..2^TOP_WIDTH, so o_top is 1..2^TOP_WIDTH-1; o_compare is 1..o_top.
  - 0% duty (constant low) and 100% duty (compare=top+1, constant high) have no rising edges. Both are reported via o_timeout, with o_level 0 or 1.
- Holding behaviour: o_top/o_compare/o_level hold their values between strobes. o_valid and o_timeout are never high together.
- Reset values: o_top=0, o_compare=0, o_valid=0, o_timeout=0, o_level=0, state=IDLE, counters=0.
- Reset mid-measurement: the partial cycle is discarded, with no strobe. The first o_valid needs two rises after reset release.
- Glitches shorter than one clock may be missed; no deglitch filter in this block.

Decomposition:
- Shared package pwm_pkg:
  - PWM_TOP_WIDTH=8
  - state enum {ST_IDLE, ST_MEASURE}
  - localparam PERIOD_MAX = 2^TOP_WIDTH
  - these are shared with pwm and pwm_note_sequencer
- One sub-module: bit_synchronizer (parameters STAGES, RESET_VALUE). It is reusable for other PMOD inputs.

Test Plan:
- Loopback from pwm with top=99, compare=25 → after the 2nd rise, o_valid every 100 cycles with o_top=99, o_compare=25, o_timeout never asserted.
- Minimum period (pin 1 clock high, 1 clock low) → o_valid every 2 cycles, o_top=1, o_compare=1.
- Maximum period, top=255, compare=128 → o_top=255, o_compare=128, no timeout. Then period 257 (high 1, low 256) → o_timeout 257 cycles after the rise, o_level=0, o_valid not asserted.
- Pin held high after measurements (compare=top+1, top=9) → exactly one o_timeout pulse with o_level=1. After the pin returns to top=9, compare=4: first rise → no strobe; second rise → o_valid, o_top=9, o_compare=4.
- Reset:
  - pin high during reset release, then pin low 3, high 5, low 5, high → single o_valid with o_top=9, o_compare=5, and no earlier strobe.
  - i_rst asserted mid-period → all outputs 0 the next cycle, with no strobe until two further rises.
- Latency check, SYNC_STAGES=2 and 3 → o_valid appears exactly SYNC_STAGES+1 clock edges after the pin rise is first sampled.
